load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: aligns core accesses onto a word-wide memory port and extends load results.
// Latency: done two cycles after the request at best; stall holds the core while busy, memory paces via mem_valid.
module load_store_unit #(
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              store,
    input  logic [2:0]        funct3,
    input  logic [DATA_W-1:0] addr,
    input  logic [DATA_W-1:0] store_data,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] load_data,
    output logic              err_misaligned,
    output logic              err_timeout,
    output logic              mem_request,
    output logic              mem_re_we,
    output logic [STRB_W-1:0] mem_mask,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_valid
);

    localparam int         OFF_W   = $clog2(STRB_W);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [1:0]        size_q;
    logic              sign_q;
    logic [OFF_W-1:0]  off_q;
    logic              done_q;
    logic              err_mis_q;
    logic              err_to_q;
    logic [DATA_W-1:0] load_data_q;
    logic              mem_request_q;
    logic              mem_re_we_q;
    logic [STRB_W-1:0] mem_mask_q;
    logic [DATA_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;

    logic              illegal_d;
    logic              misaligned_d;
    logic [STRB_W-1:0] size_mask_d;
    logic [STRB_W-1:0] mask_d;
    logic [DATA_W-1:0] wdata_d;
    logic [DATA_W-1:0] addr_d;
    logic [DATA_W-1:0] shifted_d;
    logic [DATA_W-1:0] ext_d;

    always_comb begin
        // A simultaneous load+store is a load, so only a pure store rejects the unsigned encodings.
        illegal_d = (funct3 == 3'b111) || (store && !load && funct3[2]) ||
                    ((DATA_W == 32) && ((funct3 == 3'b011) || (funct3 == 3'b110)));

        misaligned_d = 1'b0;
        size_mask_d  = '1;
        wdata_d      = store_data;
        case (funct3[1:0])
            2'd0: begin
                size_mask_d = STRB_W'(1);
                wdata_d     = {STRB_W{store_data[7:0]}};
            end
            2'd1: begin
                misaligned_d = addr[0];
                size_mask_d  = STRB_W'(3);
                wdata_d      = {(STRB_W/2){store_data[15:0]}};
            end
            2'd2: begin
                misaligned_d = |addr[1:0];
                size_mask_d  = STRB_W'(15);
                wdata_d      = {(STRB_W/4){store_data[31:0]}};
            end
            default: begin
                misaligned_d = |addr[2:0];
            end
        endcase
        mask_d = size_mask_d << addr[OFF_W-1:0];

        addr_d             = addr;
        addr_d[OFF_W-1:0]  = '0;

        shifted_d = mem_rdata >> {off_q, 3'b000};
        ext_d     = shifted_d;
        case (size_q)
            2'd0:    for (int i = 8; i < DATA_W; i++)  ext_d[i] = sign_q & shifted_d[7];
            2'd1:    for (int i = 16; i < DATA_W; i++) ext_d[i] = sign_q & shifted_d[15];
            2'd2:    for (int i = 32; i < DATA_W; i++) ext_d[i] = sign_q & shifted_d[31];
            default: ext_d = mem_rdata;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            size_q        <= '0;
            sign_q        <= 1'b0;
            off_q         <= '0;
            done_q        <= 1'b0;
            err_mis_q     <= 1'b0;
            err_to_q      <= 1'b0;
            load_data_q   <= '0;
            mem_request_q <= 1'b0;
            mem_re_we_q   <= 1'b0;
            mem_mask_q    <= '0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (load || store) begin
                        if (illegal_d || misaligned_d) begin
                            state_q     <= DONE;
                            done_q      <= 1'b1;
                            err_mis_q   <= 1'b1;
                            load_data_q <= '0;
                        end else begin
                            state_q       <= BUSY;
                            cnt_q         <= '0;
                            size_q        <= funct3[1:0];
                            sign_q        <= !funct3[2];
                            off_q         <= addr[OFF_W-1:0];
                            mem_request_q <= 1'b1;
                            mem_re_we_q   <= !load;
                            mem_mask_q    <= mask_d;
                            mem_addr_q    <= addr_d;
                            mem_wdata_q   <= wdata_d;
                        end
                    end
                end
                BUSY: begin
                    if (mem_valid) begin
                        state_q       <= DONE;
                        done_q        <= 1'b1;
                        mem_request_q <= 1'b0;
                        load_data_q   <= mem_re_we_q ? '0 : ext_d;
                    end else if (cnt_q == TO_LAST) begin
                        state_q       <= DONE;
                        done_q        <= 1'b1;
                        err_to_q      <= 1'b1;
                        mem_request_q <= 1'b0;
                        load_data_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    err_mis_q <= 1'b0;
                    err_to_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Gated by rst so the core is released the moment reset is applied.
    assign stall = !rst && ((state_q == BUSY) || ((state_q == IDLE) && (load || store)));

    assign done           = done_q;
    assign err_misaligned = err_mis_q;
    assign err_timeout    = err_to_q;
    assign load_data      = load_data_q;
    assign mem_request    = mem_request_q;
    assign mem_re_we      = mem_re_we_q;
    assign mem_mask       = mem_mask_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;

endmodule
